pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 32-bit RISC core. It drives the write enables of PC and IF/ID, and the `HIT` enable and bubble input of the ID/EX latch. It detects load-use hazards and steers branch flushes. It runs the cache-miss refill handshake with memory, freezing the pipeline until the refill completes or times out.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_load_use.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_RESUME = 2'd2,
        ST_ERROR  = 2'd3
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         STALL_W  = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// rtl/pipe_hazard_ctrl_load_use.sv - load-use hazard detector (load in EX feeding a source in ID)
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             lu
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign lu = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline enables, load-use/branch hazards and cache-miss refill FSM; optional stall counter under PIPE_STALL_CNT_EN
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MISS_TIMEOUT = 64,
    parameter int REG_W        = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cache_hit,
    input  logic               mem_ack,
    input  logic               ex_mem_read,
    input  logic [REG_W-1:0]   ex_rt,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               branch_taken,
    output logic               pc_we,
    output logic               if_id_we,
    output logic               id_ex_hit,
    output logic               id_ex_bubble,
    output logic               if_id_flush,
    output logic               mem_req,
    output logic               err,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam int CNT_W = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;

    pipe_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             timeout;

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .lu          (lu)
    );

    assign timeout = (cnt_q == CNT_W'(MISS_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_RUN:    if (!cache_hit) state_d = ST_MISS;
            // ack has priority over an expiring timeout in the same cycle
            ST_MISS: begin
                if (mem_ack)      state_d = ST_RESUME;
                else if (timeout) state_d = ST_ERROR;
                else              cnt_d   = cnt_q + 1'b1;
            end
            ST_RESUME: state_d = ST_RUN;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RUN;
        endcase
    end

    // Outputs are forced low while reset is asserted, including the combinational RUN path
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_hit    = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        mem_req      = 1'b0;
        err          = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ST_RUN: begin
                    id_ex_hit    = cache_hit;
                    pc_we        = cache_hit && !lu;
                    if_id_we     = cache_hit && !lu;
                    id_ex_bubble = cache_hit && lu;
                    if_id_flush  = cache_hit && !lu && branch_taken;
                end
                ST_MISS:   mem_req = 1'b1;
                ST_ERROR:  err     = 1'b1;
                default:   ;
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    assign stall_d = (!pc_we && (stall_q != {STALL_W{1'b1}})) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed table-driven bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_hit, mem_ack, ex_mem_read, branch_taken;
    logic [4:0]  ex_rt, id_rs, id_rt;

    logic        pc_we, if_id_we, id_ex_hit, id_ex_bubble, if_id_flush, mem_req, err;
    logic [15:0] stall_cycles;
    logic        t_pc_we, t_if_id_we, t_id_ex_hit, t_id_ex_bubble, t_if_id_flush, t_mem_req, t_err;
    logic [15:0] t_stall_cycles;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       hit;
        logic       rd;
        logic [4:0] rt;
        logic [4:0] rs;
        logic [4:0] rt2;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t vt [8];

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cache_hit(cache_hit), .mem_ack(mem_ack),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .branch_taken(branch_taken), .pc_we(pc_we), .if_id_we(if_id_we),
        .id_ex_hit(id_ex_hit), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .mem_req(mem_req), .err(err), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.MISS_TIMEOUT(8)) dut_to (
        .clk(clk), .rst_n(rst_n), .cache_hit(cache_hit), .mem_ack(mem_ack),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .branch_taken(branch_taken), .pc_we(t_pc_we), .if_id_we(t_if_id_we),
        .id_ex_hit(t_id_ex_hit), .id_ex_bubble(t_id_ex_bubble), .if_id_flush(t_if_id_flush),
        .mem_req(t_mem_req), .err(t_err), .stall_cycles(t_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_main();
        return 32'({pc_we, if_id_we, id_ex_hit, id_ex_bubble, if_id_flush, mem_req, err, stall_cycles});
    endfunction

    function automatic logic [31:0] outs_to();
        return 32'({t_pc_we, t_if_id_we, t_id_ex_hit, t_id_ex_bubble, t_if_id_flush, t_mem_req, t_err, t_stall_cycles});
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outs", outs_main(), 32'd0);
        chk("reset_outs_to", outs_to(), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    int low_cnt, req_cnt;

    initial begin
        vt[0] = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 6'b111000};
        vt[1] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 6'b001100};
        vt[2] = '{1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 6'b001100};
        vt[3] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'b111000};
        vt[4] = '{1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 6'b111010};
        vt[5] = '{1'b1, 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 6'b111010};
        vt[6] = '{1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 6'b001100};
        vt[7] = '{1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 6'b111000};

        rst_n = 1'b0; cache_hit = 1'b1; mem_ack = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        do_reset();

        // load-use: one bubble, then normal flow
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
        #1;
        chk("lu_stall", 32'({pc_we, if_id_we, id_ex_bubble}), 32'b001);
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("lu_after", 32'({pc_we, if_id_we, id_ex_bubble}), 32'b110);
        tick();

        // miss with ack sampled on the 10th MISS cycle
        cache_hit = 1'b0; low_cnt = 0; req_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (!pc_we) low_cnt++;
            if (mem_req) req_cnt++;
            if (c == 11) chk("miss_req_drop", 32'(mem_req), 32'd0);
            if (c == 10) mem_ack = 1'b1;
            if (c == 11) mem_ack = 1'b0;
            if (c >= 11) cache_hit = 1'b1;
            tick();
        end
        chk("miss_pc_low", 32'(low_cnt), 32'd12);
        chk("miss_req_high", 32'(req_cnt), 32'd10);
        #1;
        chk("miss_back_run", 32'({pc_we, mem_req}), 32'b10);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'd13);
`else
        chk("stall_cycles", 32'(stall_cycles), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cache_hit = vt[i].hit; ex_mem_read = vt[i].rd; ex_rt = vt[i].rt;
            id_rs = vt[i].rs; id_rt = vt[i].rt2; branch_taken = vt[i].br;
            #1;
            chk($sformatf("vec%0d", i),
                32'({pc_we, if_id_we, id_ex_hit, id_ex_bubble, if_id_flush, mem_req}),
                32'(vt[i].exp));
            tick();
        end

        // miss + load-use + branch together: miss wins, no flush
        cache_hit = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd6; id_rs = 5'd6; branch_taken = 1'b1;
        #1;
        chk("simul_run", 32'({pc_we, id_ex_bubble, if_id_flush, id_ex_hit}), 32'b0000);
        tick();
        chk("simul_miss", 32'({mem_req, if_id_flush}), 32'b10);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("simul_resume", 32'({pc_we, mem_req, if_id_flush}), 32'b000);
        tick();
        cache_hit = 1'b1; ex_mem_read = 1'b0;
        #1;
        chk("branch_flush", 32'({pc_we, if_id_flush}), 32'b11);
        branch_taken = 1'b0;
        tick();

        // reset asserted during the third MISS cycle
        do_reset();
        cache_hit = 1'b0;
        tick(); tick(); tick();
        chk("mid_miss_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_miss_rst", outs_main(), 32'd0);
        chk("mid_miss_rst_to", outs_to(), 32'd0);
        tick();
        cache_hit = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_run", 32'({pc_we, mem_req, err}), 32'b100);
        tick();

        // timeout: counter restarts from 0 after the reset above
        cache_hit = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("to_wait%0d", i), 32'({t_err, t_mem_req}), 32'b01);
            tick();
        end
        #1;
        chk("to_err", 32'({t_err, t_mem_req, t_pc_we}), 32'b100);
        cache_hit = 1'b1; mem_ack = 1'b1;
        tick(); tick();
        mem_ack = 1'b0;
        #1;
        chk("to_sticky",
            32'({t_pc_we, t_if_id_we, t_id_ex_hit, t_id_ex_bubble, t_if_id_flush, t_mem_req, t_err}),
            32'b0000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
